seq_shift_add_mult: RTL and testbench

//  Sequential 8x8 unsigned shift-add multiplier: one partial-product add per clock through the

---
 rtl/seq_shift_add_mult.sv | 116 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential 8x8 unsigned shift-add multiplier: one ripple add per clock, then a right shift of {carry, acc_hi, acc_lo}.
// Optional registered overflow flag enabled by defining SEQ_MULT_OVF_EN; otherwise ovf is tied low.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [2:0]       cnt;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_z;
  logic             add_cout;
  logic             carry;

  assign add_a = acc_hi;
  assign add_b = acc_lo[0] ? m_reg : '0;

  // 8-bit ripple-carry adder with cin tied low.
  // NOTE: blocking assignments here model the ripple chain; every output gets a default first so no latch is inferred.
  always_comb begin
    carry    = 1'b0;
    add_z    = '0;
    add_cout = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      add_z[i] = add_a[i] ^ add_b[i] ^ carry;
      carry    = (add_a[i] & add_b[i]) | (add_a[i] & carry) | (add_b[i] & carry);
    end
    add_cout = carry;
  end

  // The carry register is shifted into acc_hi every iteration, so it never persists and needs no flop.
  assign product = {acc_hi, acc_lo};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      m_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            m_reg  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= {add_cout, add_z, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_MULT_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      ovf <= 1'b0;
    end else if (state == RUN && cnt == 3'd7) begin
      ovf <= ({add_cout, add_z[WIDTH-1:1]} != '0);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: expected products are queued at start and checked when done pulses.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   passed     = 0;
  int   total      = 0;
  int   done_count = 0;

  seq_shift_add_mult dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.prod = 16'(x) * 16'(y);
`ifdef SEQ_MULT_OVF_EN
    e.ovf  = (e.prod[15:8] != 8'h00);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_count++;
      check("busy_done_exclusive", busy, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("product", product, e.prod);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    check("ovf_cleared_on_start", ovf, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("busy_in_run", {busy, done}, 2'b10);
      @(negedge clk);
    end
    check("done_on_9th_cycle", {busy, done}, 2'b01);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 16'h0000);
    check("reset_ovf", ovf, 1'b0);

    run_op(8'd13, 8'd11);
    check("idle_holds_product", product, 16'h008F);
    run_op(8'hFF, 8'hFF);
    run_op(8'h00, 8'hA5);
    run_op(8'hA5, 8'h00);
    run_op(8'h01, 8'hC3);

    // Start held high through a run with operand churn, then back-to-back second op.
    base = done_count;
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    sb.push_back(model(8'd7, 8'd9));
    @(negedge clk);
    check("held_start_busy", busy, 1'b1);
    a = 8'h55;
    b = 8'hAA;
    repeat (3) @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    repeat (4) @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    sb.push_back(model(8'd3, 8'd5));
    @(negedge clk);
    check("held_start_done", done, 1'b1);
    @(negedge clk);
    check("back_to_back_no_idle", {busy, done}, 2'b10);
    start = 1'b0;
    wait_done(20, "back_to_back_timeout");
    check("back_to_back_done_count", done_count - base, 2);

    // Reset during the fourth RUN cycle aborts the op without a done pulse.
    a = 8'd200;
    b = 8'd200;
    start = 1'b1;
    sb.push_back(model(8'd200, 8'd200));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    base = done_count;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 16'h0000);
    check("abort_ovf", ovf, 1'b0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_count - base, 0);
    run_op(8'd200, 8'd200);
    check("rerun_product", product, 16'h9C40);
    check("scoreboard_drained", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
